// File: rtl/kyber_enc_hash_sequencer.sv
// Sequencer for the Kyber512 ENC hash datapath: pre-hash, CPA encrypt, post-hash, capture results.
// Define KYBER_SEQ_TIMEOUT_EN to enable the *_WAIT watchdog (error pulse on expiry).
module kyber_enc_hash_sequencer #(
  parameter int unsigned DATA_W         = 256,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              hash_enable,
  output logic              hash_mode,
  input  logic              hash_done,
  output logic              enc_start,
  input  logic              enc_done,
  input  logic [DATA_W-1:0] i_message,
  input  logic [DATA_W-1:0] i_coins,
  input  logic [DATA_W-1:0] i_SS,
  output logic [DATA_W-1:0] o_message,
  output logic [DATA_W-1:0] o_coins,
  output logic [DATA_W-1:0] o_SS
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE_GO, S_PRE_WAIT, S_ENC_GO, S_ENC_WAIT, S_POST_GO, S_POST_WAIT, S_FIN
  } state_e;

  state_e state_q, state_d;
  logic   hash_done_q, enc_done_q;
  logic   hash_rise, enc_rise, timeout_hit;
  logic   busy_d, done_d, error_d, hash_enable_d, hash_mode_d, enc_start_d;
  logic   cap_pre, cap_post;

  // A done level left high from an earlier phase never counts as a new event.
  assign hash_rise = hash_done & ~hash_done_q;
  assign enc_rise  = enc_done & ~enc_done_q;

`ifdef KYBER_SEQ_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q;
  logic             in_wait, wait_rise;

  always_comb begin
    in_wait   = 1'b0;
    wait_rise = 1'b0;
    case (state_q)
      S_PRE_WAIT, S_POST_WAIT: begin in_wait = 1'b1; wait_rise = hash_rise; end
      S_ENC_WAIT:              begin in_wait = 1'b1; wait_rise = enc_rise;  end
      default: ;
    endcase
  end

  // Counter sits at zero outside wait states, so it starts from zero on every entry.
  always_ff @(posedge clk) begin
    if (!reset_n) cnt_q <= '0;
    else if (in_wait) cnt_q <= cnt_q + CNT_W'(1);
    else cnt_q <= '0;
  end

  assign timeout_hit = in_wait && !wait_rise && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg  = ^{CNT_W, TIMEOUT_CYCLES};
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; abort overrides any event in the same cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_PRE_GO;
      S_PRE_GO:    state_d = S_PRE_WAIT;
      S_PRE_WAIT:  if (hash_rise) state_d = S_ENC_GO;
                   else if (timeout_hit) state_d = S_IDLE;
      S_ENC_GO:    state_d = S_ENC_WAIT;
      S_ENC_WAIT:  if (enc_rise) state_d = S_POST_GO;
                   else if (timeout_hit) state_d = S_IDLE;
      S_POST_GO:   state_d = S_POST_WAIT;
      S_POST_WAIT: if (hash_rise) state_d = S_FIN;
                   else if (timeout_hit) state_d = S_IDLE;
      S_FIN:       state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
    if (abort) state_d = S_IDLE;
  end

  // Output logic: decoded from the next state and registered, so pulses align with state
  always_comb begin
    busy_d        = (state_d != S_IDLE);
    done_d        = (state_d == S_FIN);
    hash_enable_d = (state_d == S_PRE_GO) || (state_d == S_POST_GO);
    hash_mode_d   = (state_d == S_POST_GO) || (state_d == S_POST_WAIT);
    enc_start_d   = (state_d == S_ENC_GO);
    error_d       = timeout_hit && !abort;
    cap_pre       = (state_q == S_PRE_WAIT) && (state_d == S_ENC_GO);
    cap_post      = (state_q == S_POST_WAIT) && (state_d == S_FIN);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      busy        <= 1'b0;
      done        <= 1'b0;
      error       <= 1'b0;
      hash_enable <= 1'b0;
      hash_mode   <= 1'b0;
      enc_start   <= 1'b0;
      hash_done_q <= 1'b0;
      enc_done_q  <= 1'b0;
      o_message   <= '0;
      o_coins     <= '0;
      o_SS        <= '0;
    end else begin
      busy        <= busy_d;
      done        <= done_d;
      error       <= error_d;
      hash_enable <= hash_enable_d;
      hash_mode   <= hash_mode_d;
      enc_start   <= enc_start_d;
      hash_done_q <= hash_done;
      enc_done_q  <= enc_done;
      if (cap_pre) begin
        o_message <= i_message;
        o_coins   <= i_coins;
      end
      if (cap_post) o_SS <= i_SS;
    end
  end

endmodule

// File: tb/tb_kyber_enc_hash_sequencer.sv
// Self-checking bench for kyber_enc_hash_sequencer: directed flows with randomized data and latencies.
module tb_kyber_enc_hash_sequencer;

  localparam int unsigned W = 256;
`ifdef KYBER_SEQ_TIMEOUT_EN
  localparam int HL1 = 10, EL1 = 12, MAXL = 10;
`else
  localparam int HL1 = 20, EL1 = 50, MAXL = 30;
`endif

  logic         clk = 1'b0;
  logic         reset_n, start, abort, hash_done, enc_done;
  logic         busy, done, error, hash_enable, hash_mode, enc_start;
  logic [W-1:0] i_message, i_coins, i_SS, o_message, o_coins, o_SS;

  int checks = 0;
  int errors = 0;
  int n_he = 0, n_es = 0, n_done = 0, n_err = 0;

  kyber_enc_hash_sequencer #(.DATA_W(W), .CNT_W(16), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
    .busy(busy), .done(done), .error(error),
    .hash_enable(hash_enable), .hash_mode(hash_mode), .hash_done(hash_done),
    .enc_start(enc_start), .enc_done(enc_done),
    .i_message(i_message), .i_coins(i_coins), .i_SS(i_SS),
    .o_message(o_message), .o_coins(o_coins), .o_SS(o_SS)
  );

  always #5 clk = ~clk;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (hash_enable) n_he++;
    if (enc_start)   n_es++;
    if (done)        n_done++;
    if (error)       n_err++;
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chkn(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rnd256();
    logic [W-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic chk_idle_zero(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_error"}, error, 1'b0);
    chk1({tag, "_hash_en"}, hash_enable, 1'b0);
    chk1({tag, "_hash_mode"}, hash_mode, 1'b0);
    chk1({tag, "_enc_start"}, enc_start, 1'b0);
  endtask

  // Launch a request and run the pre-hash phase; returns in ENC_WAIT.
  task automatic go_to_enc_wait(input int hl, input logic [W-1:0] m, input logic [W-1:0] c);
    start = 1'b1; tick(); start = 1'b0;
    chk1("pre_go_hash_en", hash_enable, 1'b1);
    chk1("pre_go_mode", hash_mode, 1'b0);
    i_message = m; i_coins = c;
    for (int k = 0; k < hl; k++) tick();
    hash_done = 1'b1; tick(); hash_done = 1'b0;
    chk1("enc_go_start", enc_start, 1'b1);
    chkw("cap_msg", o_message, m);
    chkw("cap_coins", o_coins, c);
    tick();
  endtask

  // One complete request with modelled hash/encrypt latencies.
  task automatic do_flow(input int hl, input int el, input logic [W-1:0] m, input logic [W-1:0] c,
                         input logic [W-1:0] s, input bit hold, input bit poke);
    logic [W-1:0] ss_before;
    int he0, es0, d0;
    ss_before = o_SS;
    he0 = n_he; es0 = n_es; d0 = n_done;
    start = 1'b1; tick(); start = 1'b0;
    chk1("flow_pre_en", hash_enable, 1'b1);
    chk1("flow_pre_mode", hash_mode, 1'b0);
    chk1("flow_pre_busy", busy, 1'b1);
    i_message = m; i_coins = c;
    for (int k = 0; k < hl; k++) begin
      if (poke && k == 1) start = 1'b1;
      tick(); start = 1'b0;
      chk1("flow_prewait_en", hash_enable, 1'b0);
    end
    hash_done = 1'b1; tick();
    if (!hold) hash_done = 1'b0;
    chk1("flow_enc_start", enc_start, 1'b1);
    chk1("flow_enc_mode", hash_mode, 1'b0);
    chkw("flow_msg", o_message, m);
    chkw("flow_coins", o_coins, c);
    i_message = rnd256(); i_coins = rnd256();
    for (int k = 0; k < el; k++) begin
      if (poke && k == 1) start = 1'b1;
      tick(); start = 1'b0;
      chk1("flow_encwait_en", hash_enable, 1'b0);
      chk1("flow_encwait_es", enc_start, 1'b0);
    end
    enc_done = 1'b1; tick(); enc_done = 1'b0;
    chk1("flow_post_en", hash_enable, 1'b1);
    chk1("flow_post_mode", hash_mode, 1'b1);
    i_SS = s;
    if (hold) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        chk1("hold_no_done", done, 1'b0);
        chkw("hold_ss_kept", o_SS, ss_before);
      end
      hash_done = 1'b0; tick();
      chk1("hold_still_wait", busy, 1'b1);
    end else begin
      for (int k = 0; k < hl; k++) begin
        tick();
        chk1("flow_postwait_mode", hash_mode, 1'b1);
        chk1("flow_postwait_done", done, 1'b0);
      end
    end
    hash_done = 1'b1; tick(); hash_done = 1'b0;
    chk1("flow_done", done, 1'b1);
    chk1("flow_fin_mode", hash_mode, 1'b0);
    chk1("flow_fin_busy", busy, 1'b1);
    chkw("flow_ss", o_SS, s);
    chkw("flow_msg_hold", o_message, m);
    tick();
    chk1("flow_done_clear", done, 1'b0);
    chk1("flow_busy_low", busy, 1'b0);
    tick();
    chkn("flow_n_hash_en", n_he - he0, 2);
    chkn("flow_n_enc_start", n_es - es0, 1);
    chkn("flow_n_done", n_done - d0, 1);
  endtask

  initial begin
    logic [W-1:0] m, c, s;
    int he0, d0, e0;
    reset_n = 1'b0; start = 1'b0; abort = 1'b0; hash_done = 1'b0; enc_done = 1'b0;
    i_message = rnd256(); i_coins = rnd256(); i_SS = rnd256();
    tick(); tick();
    chk_idle_zero("reset");
    chkw("reset_msg", o_message, '0);
    chkw("reset_ss", o_SS, '0);
    reset_n = 1'b1; tick();
    chk_idle_zero("post_reset");

    // Full flow with reference-vector style data
    m = rnd256(); m[255:224] = 32'hc20634f3; m[15:0] = 16'h0ff7;
    c = rnd256(); c[255:224] = 32'h40f247be; c[15:0] = 16'h20a4;
    s = rnd256(); s[255:224] = 32'hf66417cd; s[15:0] = 16'h2c5f;
    do_flow(HL1, EL1, m, c, s, 1'b0, 1'b0);

    // Randomized latencies and data
    for (int t = 0; t < 3; t++)
      do_flow($urandom_range(2, MAXL), $urandom_range(2, MAXL), rnd256(), rnd256(), rnd256(), 1'b0, 1'b0);

    // Level-held hash_done must not advance later phases
    do_flow($urandom_range(2, MAXL), $urandom_range(2, MAXL), rnd256(), rnd256(), rnd256(), 1'b1, 1'b0);

    // start pulses while busy are ignored
    do_flow($urandom_range(3, MAXL), $urandom_range(3, MAXL), rnd256(), rnd256(), rnd256(), 1'b0, 1'b1);

    // start and abort together in IDLE: stay idle
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk1("start_abort_busy", busy, 1'b0);
    chk1("start_abort_en", hash_enable, 1'b0);

    // Abort in ENC_WAIT with enc_done rising the same cycle
    m = rnd256(); c = rnd256();
    go_to_enc_wait($urandom_range(2, MAXL), m, c);
    tick(); tick();
    he0 = n_he; d0 = n_done;
    abort = 1'b1; enc_done = 1'b1; tick(); abort = 1'b0;
    chk_idle_zero("abort");
    chkw("abort_msg_kept", o_message, m);
    chkw("abort_coins_kept", o_coins, c);
    enc_done = 1'b0; tick(); tick();
    chkn("abort_n_hash_en", n_he - he0, 0);
    chkn("abort_n_done", n_done - d0, 0);
    do_flow($urandom_range(2, MAXL), $urandom_range(2, MAXL), rnd256(), rnd256(), rnd256(), 1'b0, 1'b0);

    // Reset in POST_WAIT
    go_to_enc_wait($urandom_range(2, MAXL), rnd256(), rnd256());
    enc_done = 1'b1; tick(); enc_done = 1'b0;
    tick(); tick();
    chk1("postwait_mode", hash_mode, 1'b1);
    reset_n = 1'b0; tick(); reset_n = 1'b1;
    chk_idle_zero("midreset");
    chkw("midreset_msg", o_message, '0);
    chkw("midreset_coins", o_coins, '0);
    chkw("midreset_ss", o_SS, '0);
    tick();
    chk_idle_zero("midreset_idle");
    do_flow($urandom_range(2, MAXL), $urandom_range(2, MAXL), rnd256(), rnd256(), rnd256(), 1'b0, 1'b0);

    // Encrypt core never finishes
    e0 = n_err;
    go_to_enc_wait($urandom_range(2, MAXL), rnd256(), rnd256());
`ifdef KYBER_SEQ_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k < 16) begin
        chk1("wd_busy", busy, 1'b1);
        chk1("wd_no_err", error, 1'b0);
      end
    end
    chk1("wd_error", error, 1'b1);
    chk1("wd_idle", busy, 1'b0);
    chk1("wd_no_done", done, 1'b0);
    tick();
    chk1("wd_error_clear", error, 1'b0);
    tick();
    chkn("wd_n_err", n_err - e0, 1);
`else
    for (int k = 0; k < 40; k++) begin
      tick();
      chk1("nowd_busy", busy, 1'b1);
      chk1("nowd_err", error, 1'b0);
    end
    abort = 1'b1; tick(); abort = 1'b0;
    chk1("nowd_abort_idle", busy, 1'b0);
    tick();
    chkn("nowd_n_err", n_err - e0, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
